// File: rtl/mu0_control_fsm_pkg.sv
// Shared MU0 definitions: opcodes, ALU function codes and the control state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mu0_control_fsm_pkg;

   // Control sequencer states
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   // Instruction opcodes, ir[15:12]; 8-15 are executed as NOPs
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STO = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   // ALU function select driven on M
   localparam logic [1:0] M_PASSY = 2'b00;   // Z = Y
   localparam logic [1:0] M_ADD   = 2'b01;   // Z = X + Y
   localparam logic [1:0] M_INC   = 2'b10;   // Z = X + 1
   localparam logic [1:0] M_SUB   = 2'b11;   // Z = X - Y

   // True for opcodes that need a data-memory access in EXEC
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op <= OP_SUB);
   endfunction

endpackage

// File: rtl/mu0_control_fsm.sv
// MU0 control sequencer: FETCH/EXEC/HALT, drives datapath selects, enables and memory strobes.
// Latency: 2 cycles per instruction with mem_ack held high, +1 per memory wait cycle.
// Backpressure: strobes and address select held stable until mem_ack; enables fire only on the ack cycle.
module mu0_control_fsm
   import mu0_control_fsm_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir,
   input  logic [15:0] acc,
   input  logic        mem_ack,
   output logic [1:0]  M,
   output logic        PCen,
   output logic        IRen,
   output logic        ACCen,
   output logic        Xsel,
   output logic        Ysel,
   output logic        Asel,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        halted,
   output logic [15:0] instr_cnt
);

   state_e      state_q, state_d;
   logic [15:0] instr_cnt_q, instr_cnt_d;
   logic [3:0]  opcode;
   logic        retire;
   logic        mem_op;
   logic        unused_ir;

   assign opcode    = ir[15:12];
   assign mem_op    = is_mem_op(opcode);
   // Operand field is consumed by the datapath, not by the sequencer
   assign unused_ir = ^ir[11:0];
   assign instr_cnt = instr_cnt_q;

   // State register and retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_FETCH;
         instr_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   // Next state and all control outputs; reset forces every output low
   always_comb begin
      state_d     = state_q;
      instr_cnt_d = instr_cnt_q;
      retire      = 1'b0;
      M           = M_PASSY;
      PCen        = 1'b0;
      IRen        = 1'b0;
      ACCen       = 1'b0;
      Xsel        = 1'b0;
      Ysel        = 1'b0;
      Asel        = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      halted      = 1'b0;

      case (state_q)
         ST_FETCH: begin
            // ir <= mem[pc], pc <= pc + 1, both on the ack cycle
            Asel   = 1'b0;
            mem_rd = 1'b1;
            Xsel   = 1'b0;
            M      = M_INC;
            Ysel   = 1'b1;
            IRen   = mem_ack;
            PCen   = mem_ack;
            if (mem_ack) begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            if (mem_op) begin
               // Operand address comes from ir; wait here until memory acks
               Asel   = 1'b1;
               retire = mem_ack;
            end else begin
               retire = 1'b1;
            end
            case (opcode)
               OP_LDA: begin
                  mem_rd = 1'b1;
                  Ysel   = 1'b1;
                  M      = M_PASSY;
                  ACCen  = mem_ack;
               end
               OP_STO: begin
                  mem_wr = 1'b1;
                  Xsel   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  mem_rd = 1'b1;
                  Xsel   = 1'b1;
                  Ysel   = 1'b1;
                  M      = (opcode == OP_ADD) ? M_ADD : M_SUB;
                  ACCen  = mem_ack;
               end
               OP_JMP: begin
                  Ysel = 1'b0;
                  M    = M_PASSY;
                  PCen = 1'b1;
               end
               OP_JGE: begin
                  Ysel = 1'b0;
                  M    = M_PASSY;
                  PCen = ~acc[15];
               end
               OP_JNE: begin
                  Ysel = 1'b0;
                  M    = M_PASSY;
                  PCen = (acc != 16'h0000);
               end
               default: begin
                  // STP and NOPs: no enables
               end
            endcase
            if (retire) begin
               instr_cnt_d = instr_cnt_q + 16'd1;
               state_d     = (opcode == OP_STP) ? ST_HALT : ST_FETCH;
            end
         end

         ST_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase

      if (reset) begin
         M      = 2'b00;
         PCen   = 1'b0;
         IRen   = 1'b0;
         ACCen  = 1'b0;
         Xsel   = 1'b0;
         Ysel   = 1'b0;
         Asel   = 1'b0;
         mem_rd = 1'b0;
         mem_wr = 1'b0;
         halted = 1'b0;
      end
   end

endmodule

// File: tb/tb_mu0_control_fsm.sv
// Bench for mu0_control_fsm: behavioural datapath + memory harness, ISA-level reference model.
// Latency: checks cycle counts of 2 per instruction plus memory wait cycles.
// Backpressure: mem_ack driven always-high, fixed 3-wait, random, or reads-only.
module tb_mu0_control_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset   = 1'b1;
   logic        mem_ack = 1'b0;
   logic [15:0] ir_r    = 16'h0000;
   logic [15:0] acc_r   = 16'h0000;
   logic [15:0] pc_r    = 16'h0000;
   logic [1:0]  M;
   logic        PCen, IRen, ACCen, Xsel, Ysel, Asel, mem_rd, mem_wr, halted;
   logic [15:0] instr_cnt;

   mu0_control_fsm dut (
      .clk(clk), .reset(reset), .ir(ir_r), .acc(acc_r), .mem_ack(mem_ack),
      .M(M), .PCen(PCen), .IRen(IRen), .ACCen(ACCen),
      .Xsel(Xsel), .Ysel(Ysel), .Asel(Asel),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .instr_cnt(instr_cnt)
   );

   logic [15:0] mem     [0:4095];
   logic [15:0] mdl_mem [0:4095];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          ack_mode = 0;
   int          wait_ctr = 0;
   int          waits_obs = 0;
   bit          prev_wait = 1'b0;
   logic [15:0] prev_vec = 16'h0000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive ack on negedge, check invariants, then update datapath/memory after posedge
   task automatic step();
      logic        strobe, ack_s, was_rst, pcen_s, iren_s, accen_s, wr_s;
      logic [11:0] a;
      logic [15:0] d, x, y, z;
      @(negedge clk);
      strobe = mem_rd | mem_wr;
      case (ack_mode)
         0:       mem_ack = 1'b1;
         1:       mem_ack = strobe && (wait_ctr == 3);
         2:       mem_ack = ($urandom_range(0, 2) == 0);
         default: mem_ack = mem_rd;
      endcase
      #1;
      a = Asel ? ir_r[11:0] : pc_r[11:0];
      d = mem[a];
      x = Xsel ? acc_r : pc_r;
      y = Ysel ? d : ir_r;
      case (M)
         2'b00:   z = y;
         2'b01:   z = x + y;
         2'b10:   z = x + 16'd1;
         default: z = x - y;
      endcase
      chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      chk("en_needs_ack", {31'd0, (IRen | ACCen) & ~(mem_ack & mem_rd)}, 32'd0);
      if (reset)
         chk("reset_outs", {21'd0, M, PCen, IRen, ACCen, Xsel, Ysel, Asel, mem_rd, mem_wr, halted}, 32'd0);
      else if (prev_wait)
         chk("strobe_hold", {16'd0, mem_rd, mem_wr, Asel, Xsel, a}, {16'd0, prev_vec});
      prev_wait = !reset && strobe && !mem_ack;
      prev_vec  = {mem_rd, mem_wr, Asel, Xsel, a};
      was_rst = reset;
      ack_s   = mem_ack;
      pcen_s  = PCen;
      iren_s  = IRen;
      accen_s = ACCen;
      wr_s    = mem_wr & mem_ack;
      @(posedge clk);
      #1;
      if (was_rst) begin
         pc_r = 16'h0000; ir_r = 16'h0000; acc_r = 16'h0000; wait_ctr = 0;
      end else begin
         if (wr_s)    mem[a] = x;
         if (pcen_s)  pc_r   = z;
         if (iren_s)  ir_r   = d;
         if (accen_s) acc_r  = z;
         if (strobe && !ack_s) begin
            wait_ctr++;
            waits_obs++;
         end else begin
            wait_ctr = 0;
         end
      end
   endtask

   // Instruction-set interpreter over mdl_mem
   task automatic model_run(output int n, output int accs, output logic [15:0] macc);
      logic [15:0] pc, w, acc;
      logic [11:0] ea;
      pc = 16'h0000; acc = 16'h0000; n = 0; accs = 0;
      for (int k = 0; k < 20000; k++) begin
         w  = mdl_mem[pc[11:0]];
         ea = w[11:0];
         pc = pc + 16'd1;
         n++;
         accs++;
         if (w[15:12] <= 4'h3) accs++;
         case (w[15:12])
            4'h0: acc = mdl_mem[ea];
            4'h1: mdl_mem[ea] = acc;
            4'h2: acc = acc + mdl_mem[ea];
            4'h3: acc = acc - mdl_mem[ea];
            4'h4: pc = w;
            4'h5: if (!acc[15]) pc = w;
            4'h6: if (acc != 16'h0000) pc = w;
            default: ;
         endcase
         if (w[15:12] == 4'h7) break;
      end
      macc = acc;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   task automatic run_prog(input string tag, input int mode, output int cyc, output int n_out);
      int          n, accs, exp_w;
      logic [15:0] macc, cnt_hold;
      for (int i = 0; i < 4096; i++) mdl_mem[i] = mem[i];
      model_run(n, accs, macc);
      ack_mode = mode;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      waits_obs = 0;
      prev_wait = 1'b0;
      cyc = 0;
      while (!halted && cyc < 4000) begin
         step();
         cyc++;
      end
      exp_w = (mode == 0) ? 0 : (mode == 1) ? 3 * accs : waits_obs;
      chk({tag, " halted"}, {31'd0, halted}, 32'd1);
      chk({tag, " cycles"}, cyc, 2 * n + exp_w);
      chk({tag, " instr_cnt"}, {16'd0, instr_cnt}, {16'd0, n[15:0]});
      chk({tag, " acc"}, {16'd0, acc_r}, {16'd0, macc});
      for (int i = 0; i < 32; i++) begin
         chk({tag, " mem_lo"}, {16'd0, mem[i]}, {16'd0, mdl_mem[i]});
         chk({tag, " mem_data"}, {16'd0, mem[256 + i]}, {16'd0, mdl_mem[256 + i]});
      end
      cnt_hold = instr_cnt;
      ack_mode = 2;
      for (int i = 0; i < 3; i++) step();
      chk({tag, " stays_halted"}, {31'd0, halted}, 32'd1);
      chk({tag, " halt_quiet"}, {27'd0, PCen, IRen, ACCen, mem_rd, mem_wr}, 32'd0);
      chk({tag, " halt_cnt"}, {16'd0, instr_cnt}, {16'd0, cnt_hold});
      n_out = n;
   endtask

   // Sequential program: LDA 0x010, ADD 0x011, STO 0x012, STP
   task automatic load_seq();
      clear_mem();
      mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'h7000;
      mem[16] = 16'd5;   mem[17] = 16'd7;
   endtask

   initial begin
      int cyc, n, len, op, opd;

      // Sequential run, mem_ack tied high
      load_seq();
      run_prog("seq_ack1", 0, cyc, n);
      chk("seq_ack1 cyc8", cyc, 8);
      chk("seq_ack1 sum", {16'd0, mem[18]}, 32'd12);
      chk("seq_ack1 cnt4", {16'd0, instr_cnt}, 32'd4);

      // Same program with three wait cycles on every access
      load_seq();
      run_prog("seq_wait3", 1, cyc, n);
      chk("seq_wait3 cyc29", cyc, 29);
      chk("seq_wait3 sum", {16'd0, mem[18]}, 32'd12);

      // Branch and subtract behaviour
      clear_mem();
      mem[0]  = 16'h0100; mem[1]  = 16'h500A; mem[2]  = 16'h1110; mem[3]  = 16'h0101;
      mem[4]  = 16'h600A; mem[5]  = 16'h0102; mem[6]  = 16'h3103; mem[7]  = 16'h1111;
      mem[8]  = 16'h0104; mem[9]  = 16'h600B; mem[10] = 16'h7000; mem[11] = 16'h400D;
      mem[12] = 16'h7000; mem[13] = 16'h1112; mem[14] = 16'h7000;
      mem[256] = 16'hFFFF; mem[257] = 16'h0000; mem[258] = 16'd3; mem[259] = 16'd5;
      mem[260] = 16'd1;
      run_prog("branch", 0, cyc, n);
      chk("branch jge_fallthru", {16'd0, mem[272]}, 32'hFFFF);
      chk("branch sub", {16'd0, mem[273]}, 32'hFFFE);
      chk("branch jne_taken", {16'd0, mem[274]}, 32'd1);
      chk("branch cnt", {16'd0, instr_cnt}, 32'd13);
      chk("branch cyc", cyc, 26);

      // Illegal opcode is a 2-cycle NOP
      clear_mem();
      mem[0] = 16'hF123; mem[1] = 16'h7000;
      run_prog("illegal", 0, cyc, n);
      chk("illegal cyc", cyc, 4);
      chk("illegal cnt", {16'd0, instr_cnt}, 32'd2);

      // Reset during an STO wait aborts the write
      clear_mem();
      mem[0] = 16'h1100; mem[256] = 16'hABCD;
      ack_mode = 3;
      reset = 1'b1;
      step();
      reset = 1'b0;
      prev_wait = 1'b0;
      step();
      step();
      step();
      chk("abort wr_before", {31'd0, mem_wr}, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort wr_drop", {31'd0, mem_wr}, 32'd0);
      chk("abort no_en", {29'd0, PCen, IRen, ACCen}, 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("abort mem_kept", {16'd0, mem[256]}, 32'hABCD);
      chk("abort pc0", {16'd0, pc_r}, 32'd0);
      chk("abort fetch", {30'd0, mem_rd, Asel}, 32'd2);
      chk("abort cnt0", {16'd0, instr_cnt}, 32'd0);

      // Random forward-branching programs under all ack styles
      for (int t = 0; t < 24; t++) begin
         clear_mem();
         len = $urandom_range(4, 14);
         for (int i = 0; i < len - 1; i++) begin
            op = $urandom_range(0, 15);
            if (op == 7) op = 15;
            if (op <= 3)      opd = 256 + $urandom_range(0, 15);
            else if (op <= 6) opd = $urandom_range(i + 1, len - 1);
            else              opd = $urandom_range(0, 4095);
            mem[i] = {op[3:0], opd[11:0]};
         end
         mem[len - 1] = 16'h7000;
         for (int i = 256; i < 272; i++) mem[i] = 16'($urandom);
         run_prog("rand", t % 3, cyc, n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
